// File: rtl/uart_packet_framer_pkg.sv
// Shared types and constants for the UART packet framer.
package framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        HDR,
        DATA,
        CHK,
        END
    } state_t;

    localparam logic [7:0] DEF_START_BYTE = 8'hAA;
    localparam logic [7:0] DEF_END_BYTE   = 8'hBB;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/uart_packet_framer_if.sv
// Producer-side sample handshakes plus TX FIFO byte handshake for the framer.
interface uart_packet_framer_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4
);
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH-1:0]        valid_i;
    logic [NUM_CH-1:0]        ready_o;
    logic [7:0]               uart_data_o;
    logic                     uart_valid_o;
    logic                     uart_ready_i;
    logic                     busy_o;

    modport master (
        output data_i, valid_i, uart_ready_i,
        input  ready_o, uart_data_o, uart_valid_o, busy_o
    );

    modport slave (
        input  data_i, valid_i, uart_ready_i,
        output ready_o, uart_data_o, uart_valid_o, busy_o
    );
endinterface

// File: rtl/uart_packet_framer_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner + 1, wrapping at N-1.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic [W-1:0] winner,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic         found;
    int           k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = W'(k);
            end
        end
    end

    // Pointer starts at N-1 so channel 0 has first priority out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= W'(N - 1);
        end else if (advance) begin
            ptr <= winner;
        end
    end

endmodule

// File: rtl/uart_packet_framer.sv
// Multi-channel sample framer: arbitrates channels and emits START/HDR/DATA/[CHK]/END byte frames.
module uart_packet_framer
    import framer_pkg::*;
#(
    parameter int         DATA_W     = 16,
    parameter int         NUM_CH     = 4,
    parameter logic [7:0] START_BYTE = DEF_START_BYTE,
    parameter logic [7:0] END_BYTE   = DEF_END_BYTE,
    parameter bit         CHK_EN     = 1'b1
) (
    input logic              clk,
    input logic              rst,
    uart_packet_framer_if.slave bus
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    state_t              state;
    logic [DATA_W-1:0]   sample;
    logic [3:0]          ch_id;
    logic [3:0]          seq;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          chk;
    logic [7:0]          byte_q;
    logic                valid_q;

    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   ready;
    logic [CH_W-1:0]     grant_idx;
    logic                transfer;
    logic                consume;
    logic [7:0]          next_byte;

    function automatic logic [7:0] sample_byte(input logic [DATA_W-1:0] s, input int i);
        return s[8*i +: 8];
    endfunction

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.valid_i),
        .advance   (transfer),
        .winner    (grant_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign ready     = (state == IDLE && !rst) ? grant : '0;
    assign transfer  = |(bus.valid_i & ready);
    assign consume   = valid_q && bus.uart_ready_i;
    assign next_byte = sample_byte(sample, int'(idx) + 1);

    // Every output byte is loaded one state ahead, so the TX side sees only flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sample  <= '0;
            ch_id   <= '0;
            seq     <= '0;
            idx     <= '0;
            chk     <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        sample  <= bus.data_i[grant_idx*DATA_W +: DATA_W];
                        ch_id   <= 4'(grant_idx);
                        chk     <= '0;
                        byte_q  <= START_BYTE;
                        valid_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (consume) begin
                        byte_q <= {seq, ch_id};
                        chk    <= {seq, ch_id};
                        state  <= HDR;
                    end
                end
                HDR: begin
                    if (consume) begin
                        idx    <= '0;
                        byte_q <= sample_byte(sample, 0);
                        chk    <= chk ^ sample_byte(sample, 0);
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (consume) begin
                        if (idx == LAST_IDX) begin
                            if (CHK_EN) begin
                                byte_q <= chk;
                                state  <= CHK;
                            end else begin
                                byte_q <= END_BYTE;
                                state  <= END;
                            end
                        end else begin
                            idx    <= idx + 1'b1;
                            byte_q <= next_byte;
                            chk    <= chk ^ next_byte;
                        end
                    end
                end
                CHK: begin
                    if (consume) begin
                        byte_q <= END_BYTE;
                        state  <= END;
                    end
                end
                END: begin
                    if (consume) begin
                        seq     <= seq + 4'd1;
                        byte_q  <= '0;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o      = ready;
    assign bus.uart_data_o  = byte_q;
    assign bus.uart_valid_o = valid_q;
    assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_uart_packet_framer.sv
// Directed bench for uart_packet_framer: default 16-bit instance plus a 32-bit no-checksum instance.
module tb_uart_packet_framer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_packet_framer_if #(.DATA_W(16), .NUM_CH(4)) bus_a ();
    uart_packet_framer_if #(.DATA_W(32), .NUM_CH(4)) bus_b ();

    uart_packet_framer dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    uart_packet_framer #(.DATA_W(32), .CHK_EN(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int passes = 0;

    logic [7:0] fr [32];
    int         fr_n;
    int         busy_n;
    int         rdy_n;
    logic [3:0] rdy_mask;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_frame(input string tag);
        check({tag, " length"}, 32'(fr_n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < 32; i++)
            check($sformatf("%s byte%0d", tag, i), {24'h0, fr[i]}, {24'h0, exp_q[i]});
    endtask

    // Collect one frame from dut_a; optionally stall the TX side at byte stall_at.
    task automatic get_frame_a(input int stall_at, input int stall_len);
        int cnt;
        bit done;
        fr_n = 0; busy_n = 0; rdy_n = 0; cnt = 0; done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus_a.busy_o) busy_n++;
            if ((bus_a.ready_o & rdy_mask) != 4'b0) rdy_n++;
            if (bus_a.uart_valid_o) begin
                if (fr_n < 32) fr[fr_n] = bus_a.uart_data_o;
                fr_n++;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) bus_a.uart_ready_i = 1'b1;
                end else if (!done && fr_n - 1 == stall_at) begin
                    done = 1'b1;
                    cnt = stall_len;
                    bus_a.uart_ready_i = 1'b0;
                end
            end else if (fr_n > 0) begin
                break;
            end
        end
    endtask

    task automatic get_frame_b();
        fr_n = 0; rdy_n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus_b.busy_o && bus_b.ready_o != 4'b0) rdy_n++;
            if (bus_b.uart_valid_o) begin
                if (fr_n < 32) fr[fr_n] = bus_b.uart_data_o;
                fr_n++;
            end else if (fr_n > 0) begin
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hdr3 [4];
        logic [7:0] chk3 [4];
        int         rr_bad;
        logic [7:0] h;

        rst = 1'b1;
        bus_a.data_i = '0; bus_a.valid_i = '0; bus_a.uart_ready_i = 1'b1;
        bus_b.data_i = '0; bus_b.valid_i = '0; bus_b.uart_ready_i = 1'b1;
        rdy_mask = 4'b1111;

        // Reset state
        repeat (2) @(negedge clk);
        bus_a.valid_i = 4'b0001;
        #1;
        check("reset uart_valid", 32'(bus_a.uart_valid_o), 32'd0);
        check("reset uart_data", 32'(bus_a.uart_data_o), 32'd0);
        check("reset busy", 32'(bus_a.busy_o), 32'd0);
        check("reset ready", 32'(bus_a.ready_o), 32'd0);
        bus_a.valid_i = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // Test 1: basic frame on ch0
        bus_a.data_i[15:0] = 16'h1234;
        bus_a.valid_i = 4'b0001;
        #1;
        check("t1 ready grant", 32'(bus_a.ready_o), 32'h1);
        @(posedge clk); #1;
        check("t1 ready drop", 32'(bus_a.ready_o), 32'h0);
        bus_a.valid_i = 4'b0000;
        get_frame_a(-1, 0);
        exp_q = '{8'hAA, 8'h00, 8'h34, 8'h12, 8'h26, 8'hBB};
        check_frame("t1");
        check("t1 busy cycles", 32'(busy_n), 32'd6);
        check("t1 ready during frame", 32'(rdy_n), 32'd0);

        // Test 2: 3-cycle backpressure while 0x34 is presented
        bus_a.valid_i = 4'b0001;
        @(posedge clk); #1;
        bus_a.valid_i = 4'b0000;
        get_frame_a(2, 3);
        exp_q = '{8'hAA, 8'h10, 8'h34, 8'h34, 8'h34, 8'h34, 8'h12, 8'h36, 8'hBB};
        check_frame("t2");
        check("t2 busy cycles", 32'(busy_n), 32'd9);

        // Test 3: round-robin between ch0 and ch2 held continuously
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hdr3 = '{8'h00, 8'h12, 8'h20, 8'h32};
        chk3 = '{8'h01, 8'h10, 8'h21, 8'h30};
        bus_a.data_i = '0;
        bus_a.data_i[15:0]  = 16'h0001;
        bus_a.data_i[47:32] = 16'h0002;
        bus_a.valid_i = 4'b0101;
        rdy_mask = 4'b1010;
        rr_bad = 0;
        for (int f = 0; f < 4; f++) begin
            get_frame_a(-1, 0);
            rr_bad += rdy_n;
            check($sformatf("t3 frame%0d length", f), 32'(fr_n), 32'd6);
            check($sformatf("t3 frame%0d header", f), {24'h0, fr[1]}, {24'h0, hdr3[f]});
            check($sformatf("t3 frame%0d checksum", f), {24'h0, fr[4]}, {24'h0, chk3[f]});
        end
        bus_a.valid_i = 4'b0000;
        rdy_mask = 4'b1111;
        check("t3 ch1/ch3 never ready", 32'(rr_bad), 32'd0);

        // Test 4: sequence number wraps after 16 frames
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_a.data_i = '0;
        bus_a.data_i[31:16] = 16'hA55A;
        bus_a.valid_i = 4'b0010;
        for (int f = 0; f < 17; f++) begin
            get_frame_a(-1, 0);
            h = {4'(f), 4'h1};
            check($sformatf("t4 frame%0d length", f), 32'(fr_n), 32'd6);
            check($sformatf("t4 frame%0d header", f), {24'h0, fr[1]}, {24'h0, h});
            check($sformatf("t4 frame%0d checksum", f), {24'h0, fr[4]}, {24'h0, h ^ 8'hFF});
        end
        bus_a.valid_i = 4'b0000;

        // Test 5: 32-bit instance without checksum, valid held through the frame
        bus_b.data_i[127:96] = 32'hDEADBEEF;
        bus_b.valid_i = 4'b1000;
        get_frame_b();
        bus_b.valid_i = 4'b0000;
        exp_q = '{8'hAA, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hBB};
        check_frame("t5");
        check("t5 ready while busy", 32'(rdy_n), 32'd0);

        // Test 6: reset during DATA aborts the frame
        bus_a.data_i = '0;
        bus_a.data_i[47:32] = 16'h5678;
        bus_a.valid_i = 4'b0100;
        @(negedge clk);
        check("t6 start byte", 32'(bus_a.uart_data_o), 32'hAA);
        bus_a.valid_i = 4'b0000;
        @(negedge clk);
        check("t6 header", 32'(bus_a.uart_data_o), 32'h12);
        @(negedge clk);
        check("t6 data byte", 32'(bus_a.uart_data_o), 32'h78);
        check("t6 valid before reset", 32'(bus_a.uart_valid_o), 32'd1);
        rst = 1'b1;
        #1;
        check("t6 valid drops async", 32'(bus_a.uart_valid_o), 32'd0);
        check("t6 busy drops async", 32'(bus_a.busy_o), 32'd0);
        check("t6 data cleared", 32'(bus_a.uart_data_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_a.data_i = {16'h4444, 16'h3333, 16'h2222, 16'h0F01};
        bus_a.valid_i = 4'b1111;
        get_frame_a(-1, 0);
        bus_a.valid_i = 4'b0000;
        exp_q = '{8'hAA, 8'h00, 8'h01, 8'h0F, 8'h0E, 8'hBB};
        check_frame("t6 after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
